// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between fetch and dmem, one access at a time.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int BIN_DIG    = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               if_req,
  input  logic [BIN_DIG-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [BIN_DIG-1:0] if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [3:0]         d_be,
  input  logic [BIN_DIG-1:0] d_addr,
  input  logic [BIN_DIG-1:0] d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [BIN_DIG-1:0] d_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [BIN_DIG-1:0] mem_addr,
  output logic [BIN_DIG-1:0] mem_wdata,
  input  logic [BIN_DIG-1:0] mem_rdata,
  output logic               stall_fetch,
  output logic               stall_dmem,
  output logic [31:0]        perf_if_cnt,
  output logic [31:0]        perf_d_cnt,
  output logic [31:0]        perf_conf_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t state, state_n;
  logic [3:0] lat_cnt, lat_n, starve_cnt;
  logic drop_if, store_q, idle, resp, if_win;
  assign idle = (state == IDLE) & ~RST;
  assign resp = (state != IDLE) & (lat_cnt == 4'(MEM_LAT)) & ~RST;
  // data wins a conflict unless fetch has been starved long enough
  assign if_win = if_req & ~flush & (~d_req | (starve_cnt >= 4'(STARVE_MAX)));
  assign if_gnt = idle & if_win;
  assign d_gnt = idle & d_req & ~if_win;
  assign if_rvalid = resp & (state == BUSY_IF) & ~drop_if & ~flush;
  assign d_rvalid = resp & (state == BUSY_D);
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign d_rdata = (d_rvalid & ~store_q) ? mem_rdata : '0;
  assign mem_en = if_gnt | d_gnt;
  assign mem_we = d_gnt & d_we;
  assign mem_be = d_gnt ? d_be : {4{if_gnt}};
  assign mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  assign stall_fetch = (if_req & ~if_gnt) | ((state == BUSY_IF) & ~if_rvalid);
  assign stall_dmem = (d_req & ~d_gnt) | ((state == BUSY_D) & ~d_rvalid);
  always_comb begin
    state_n = state;
    lat_n = lat_cnt + 4'd1;
    if (state == IDLE) begin
      state_n = if_gnt ? BUSY_IF : d_gnt ? BUSY_D : IDLE;
      lat_n = 4'd1;
    end else if (lat_cnt == 4'(MEM_LAT)) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      lat_cnt <= '0;
      starve_cnt <= '0;
      drop_if <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state <= state_n;
      lat_cnt <= lat_n;
      starve_cnt <= (~if_req | if_gnt) ? '0 : (d_gnt && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
      drop_if <= (state == BUSY_IF) & ~resp & (drop_if | flush);
      if (d_gnt) store_q <= d_we;
    end
  end
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_c, d_c, conf_c;
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_c <= '0;
      d_c <= '0;
      conf_c <= '0;
    end else begin
      if_c <= if_c + 32'(if_gnt);
      d_c <= d_c + 32'(d_gnt);
      conf_c <= conf_c + 32'((state == IDLE) & if_req & d_req);
    end
  end
  assign perf_if_cnt = if_c;
  assign perf_d_cnt = d_c;
  assign perf_conf_cnt = conf_c;
`else
  assign perf_if_cnt = '0;
  assign perf_d_cnt = '0;
  assign perf_conf_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-vector bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;
  logic CLK = 0, RST = 1, flush = 0, if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0] d_be = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_fetch, stall_dmem;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, perf_if_cnt, perf_d_cnt, perf_conf_cnt;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
`ifdef ARB_PERF_CNT_EN
  localparam int EXP_IF = 2, EXP_D = 3, EXP_CONF = 3;
`else
  localparam int EXP_IF = 0, EXP_D = 0, EXP_CONF = 0;
`endif
  always #5 CLK = ~CLK;
  mem_port_arbiter #(.BIN_DIG(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_dmem(stall_dmem),
    .perf_if_cnt(perf_if_cnt), .perf_d_cnt(perf_d_cnt), .perf_conf_cnt(perf_conf_cnt)
  );
  // ctl = {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_fetch, stall_dmem}
  typedef struct {
    logic rst, fl, ir;
    logic [31:0] ia;
    logic dr, dwe;
    logic [3:0] dbe;
    logic [31:0] da, dwd, mrd;
    logic [7:0] ctl;
    logic [3:0] be;
    logic [31:0] addr, wd, ird, drd;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic rst, fl, ir, input logic [31:0] ia, input logic dr, dwe,
                              input logic [3:0] dbe, input logic [31:0] da, dwd, mrd, input logic [7:0] ctl,
                              input logic [3:0] be, input logic [31:0] addr, wd, ird, drd);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da;
    v.dwd = dwd; v.mrd = mrd; v.ctl = ctl; v.be = be; v.addr = addr; v.wd = wd; v.ird = ird; v.drd = drd;
    return v;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    @(negedge CLK);
    RST = v.rst; flush = v.fl; if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dwe;
    d_be = v.dbe; d_addr = v.da; d_wdata = v.dwd; mem_rdata = v.mrd;
  endtask
  task automatic apply(input string tag, input vec_t v);
    drive(v);
    #1;
    check({tag, " ctl"}, {24'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_fetch, stall_dmem}, {24'd0, v.ctl});
    check({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, v.be});
    check({tag, " mem_addr"}, mem_addr, v.addr);
    check({tag, " mem_wdata"}, mem_wdata, v.wd);
    check({tag, " if_rdata"}, if_rdata, v.ird);
    check({tag, " d_rdata"}, d_rdata, v.drd);
  endtask
  task automatic check_perf(input string tag, input int ei, input int ed, input int ec);
    check({tag, " perf_if"}, perf_if_cnt, ei);
    check({tag, " perf_d"}, perf_d_cnt, ed);
    check({tag, " perf_conf"}, perf_conf_cnt, ec);
  endtask
  initial begin
    // fetch-only accesses: grant, wait, response, earliest regrant at T+3
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0000, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,'h100,0,0,0,0,0,0, 8'b1000_1000, 4'hF,'h100,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0010, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,'h104,0,0,0,0,0,'h13, 8'b0100_0010, 0,0,0,'h13,0));
    tbl.push_back(mk(0,0,1,'h104,0,0,0,0,0,0, 8'b1000_1000, 4'hF,'h104,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0010, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h17, 8'b0100_0000, 0,0,0,'h17,0));
    // conflict with a store: data first, fetch at T+3
    tbl.push_back(mk(0,0,1,'h108,1,1,4'b0011,'h200,'hABCD,0, 8'b0010_1110, 4'b0011,'h200,'hABCD,0,0));
    tbl.push_back(mk(0,0,1,'h108,0,0,0,0,0,0, 8'b0000_0011, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,'h108,0,0,0,0,0,'hDEADBEEF, 8'b0001_0010, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,'h108,0,0,0,0,0,0, 8'b1000_1000, 4'hF,'h108,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0010, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h33, 8'b0100_0000, 0,0,0,'h33,0));
    // starvation: four data loads, then fetch, then data again
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,0, 8'b0010_1010, 4'hF,'h300,0,0,0));
      tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,0, 8'b0000_0011, 0,0,0,0,0));
      tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,32'(17*(k+1)), 8'b0001_0011, 0,0,0,0,32'(17*(k+1))));
    end
    tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,0, 8'b1000_1001, 4'hF,'h10C,0,0,0));
    tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,0, 8'b0000_0011, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,'h55, 8'b0100_0011, 0,0,0,'h55,0));
    tbl.push_back(mk(0,0,1,'h10C,1,0,4'hF,'h300,0,0, 8'b0010_1010, 4'hF,'h300,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0001, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,'h66, 8'b0001_0000, 0,0,0,0,'h66));
    repeat (2) @(posedge CLK);
    #1;
    check_perf("reset", 0, 0, 0);
    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);
    // flush of an in-flight fetch, then flush in IDLE blocks a lone fetch
    apply("fl_gnt", mk(0,0,1,'h400,0,0,0,0,0,0, 8'b1000_1000, 4'hF,'h400,0,0,0));
    apply("fl_t1", mk(0,1,0,0,0,0,0,0,0,0, 8'b0000_0010, 0,0,0,0,0));
    apply("fl_t2", mk(0,0,0,0,0,0,0,0,0,'h99, 8'b0000_0010, 0,0,0,0,0));
    apply("fl_idle", mk(0,1,1,'h404,0,0,0,0,0,0, 8'b0000_0010, 0,0,0,0,0));
    apply("fl_regnt", mk(0,0,1,'h404,0,0,0,0,0,0, 8'b1000_1000, 4'hF,'h404,0,0,0));
    apply("fl_w", mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0010, 0,0,0,0,0));
    apply("fl_rv", mk(0,0,0,0,0,0,0,0,0,'h77, 8'b0100_0000, 0,0,0,'h77,0));
    // flush still lets data win and does not disturb a data access
    apply("fl_d", mk(0,1,1,'h408,1,0,4'hF,'h600,0,0, 8'b0010_1010, 4'hF,'h600,0,0,0));
    apply("fl_dw", mk(0,1,0,0,0,0,0,0,0,0, 8'b0000_0001, 0,0,0,0,0));
    apply("fl_drv", mk(0,1,0,0,0,0,0,0,0,'h88, 8'b0001_0000, 0,0,0,0,'h88));
    // reset in the middle of a load
    apply("rs_gnt", mk(0,0,0,0,1,0,4'hF,'h500,0,0, 8'b0010_1000, 4'hF,'h500,0,0,0));
    drive(mk(1,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0));
    apply("rs_t2", mk(0,0,0,0,0,0,0,0,0,'hAA, 8'b0000_0000, 0,0,0,0,0));
    apply("rs_t3", mk(0,0,0,0,1,0,4'hF,'h504,0,0, 8'b0010_1000, 4'hF,'h504,0,0,0));
    apply("rs_w", mk(0,0,0,0,0,0,0,0,0,0, 8'b0000_0001, 0,0,0,0,0));
    apply("rs_rv", mk(0,0,0,0,0,0,0,0,0,'hBB, 8'b0001_0000, 0,0,0,0,'hBB));
    // performance counters: 3 conflicts / 3 data grants, then 2 lone fetch grants
    drive(mk(1,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0));
    drive(mk(1,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0));
    #1;
    check_perf("perf_rst", 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(mk(0,0,1,'h700,1,0,4'hF,'h800,0,0, 0, 0,0,0,0,0));
    for (int i = 0; i < 6; i++) drive(mk(0,0,1,'h700,0,0,0,0,0,0, 0, 0,0,0,0,0));
    for (int i = 0; i < 3; i++) drive(mk(0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0));
    #1;
    check_perf("perf", EXP_IF, EXP_D, EXP_CONF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the dmem stage (loads/stores).
- Sits between the pipeline stages and the memory macro.
- Issues one access at a time and returns each response to the port that issued it.
- Data has priority, with a starvation guard for fetch. Fetch responses are dropped on a control-hazard flush.

Parameters:
- BIN_DIG, 32, address/data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..8.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins; legal range 1..15.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- flush  in  1  control hazard; discards pending or in-flight fetch
- if_req  in  1  fetch request
- if_addr  in  BIN_DIG  fetch address
- if_gnt  out  1  fetch granted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  BIN_DIG  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store
- d_be  in  4  byte enables
- d_addr  in  BIN_DIG  data address
- d_wdata  in  BIN_DIG  store data
- d_gnt  out  1  data granted (1-cycle pulse)
- d_rvalid  out  1  data completion (1-cycle pulse, loads and stores)
- d_rdata  out  BIN_DIG  load data
- mem_en, mem_we  out  1  memory strobe, write enable
- mem_be  out  4  memory byte enables
- mem_addr, mem_wdata  out  BIN_DIG  memory address and write data
- mem_rdata  in  BIN_DIG  memory read data
- stall_fetch, stall_dmem  out  1  stage must hold
- perf_if_cnt, perf_d_cnt, perf_conf_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_D, plus a latency counter. Only one access is outstanding at a time.

Handshake:
- A requester holds req, addr, we, be and wdata stable until it sees gnt.
- It may drop req in the cycle after gnt.

Arbitration:
- Arbitration happens only in IDLE.
- If only one req is high, that port is granted.
- If both are high, d wins unless starve_cnt >= STARVE_MAX, in which case if wins.
- A fetch grant is suppressed in any cycle where flush=1; d may still be granted that cycle.

Grant cycle T:
- gnt pulses; mem_en=1; mem_* are driven combinationally from the granted port.
- For a fetch grant: mem_we=0 and mem_be=4'hF.
- The FSM enters BUSY_IF or BUSY_D.

Response:
- At cycle T+MEM_LAT, rvalid pulses for the owning port; rdata = mem_rdata.
- d_rdata = 0 for stores.
- The FSM returns to IDLE at T+MEM_LAT+1. The earliest next grant is T+MEM_LAT+1, giving throughput of one access per MEM_LAT+1 cycles.

starve_cnt (4-bit):
- Increments (saturating at 15) at each IDLE cycle where if_req=1 and d was granted.
- Clears on a fetch grant or whenever if_req=0.

Flush:
- If flush=1 at any cycle while in BUSY_IF, set drop_if. The FSM still waits out the full latency, and if_rvalid is not asserted for that access.
- drop_if clears on return to IDLE. Flush has no effect on BUSY_D.

Stalls:
- stall_fetch = if_req & ~if_gnt, OR (BUSY_IF & ~if_rvalid).
- stall_dmem = d_req & ~d_gnt, OR (BUSY_D & ~d_rvalid).

Reset and idle values:
- RST has priority over everything; mid-operation it aborts the access and no rvalid is produced.
- On reset: FSM=IDLE, counters 0, starve_cnt=0, drop_if=0.
- All gnt, rvalid, mem_en and mem_we outputs are 0; rdata, mem_addr, mem_wdata and mem_be are 0.
- In cycles without a grant, mem_* are driven 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- With the macro defined:
  - perf_if_cnt counts fetch grants.
  - perf_d_cnt counts data grants.
  - perf_conf_cnt counts IDLE cycles with if_req & d_req both high.
  - All three are 32-bit, wrap at 2^32, and clear on RST.
- Without the macro: counter logic is absent and the three ports are tied to 0.

Test Plan:
- Fetch only, MEM_LAT=2: if_req=1, if_addr=0x100, grant at T; mem_rdata=0x00000013 at T+2 -> if_gnt at T, if_rvalid=1 and if_rdata=0x13 at T+2, next grant at T+3.
- Both req in IDLE, d_we=1, d_addr=0x200, d_be=4'b0011, d_wdata=0xABCD -> d_gnt, mem_we=1, mem_be=4'b0011; d_rvalid at T+2 with d_rdata=0; fetch granted at T+3.
- Starvation: d_req and if_req held high continuously, STARVE_MAX=4 -> 4 data grants, then the 5th grant goes to fetch; the following grant returns to d.
- Flush: fetch granted at T, flush=1 at T+1 -> no if_rvalid at T+2; FSM idle at T+3. Flush=1 in IDLE with only if_req -> no grant that cycle.
- Reset mid-access: RST at T+1 of a load -> no d_rvalid; all outputs 0 at T+2; a request at T+3 is granted normally.
- ARB_PERF_CNT_EN defined: 3 conflict cycles, 3 d grants and 2 if grants -> perf_conf_cnt=3, perf_d_cnt=3, perf_if_cnt=2. Macro undefined -> all counters read 0.
